// File: rtl/uart_host_protocol.sv
// UART host protocol engine.
// Turns a parallel read/write request into a byte frame for an external UART
// transmitter, then waits for a one-byte reply:
//   write frame: 0x57, A[15:8], A[7:0], D   -> reply 0x4B expected
//   read  frame: 0x52, A[15:8], A[7:0]      -> reply is the data byte
// A bounded reply wait reports o_timeout. Reset assertion is immediate;
// release is synchronised internally so the FSM never leaves reset
// metastably.
module uart_host_protocol #(
    parameter int TIMEOUT = 250000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdat,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_rdat,
    output logic        o_err,
    output logic        o_timeout,
    output logic        o_uart_send_pulse,
    output logic [7:0]  o_uart_dat,
    input  logic        i_uart_send_ready,
    input  logic        i_uart_received_pulse,
    input  logic [7:0]  i_uart_dat
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] WRITE_ACK = 8'h4B;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND        = 3'd1;
    localparam logic [2:0] ST_WAIT_TXLOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_TXHIGH = 3'd3;
    localparam logic [2:0] ST_WAIT_RX     = 3'd4;
    localparam logic [2:0] ST_DONE        = 3'd5;

    // Frame byte selected by position; the command byte encodes direction.
    function automatic logic [7:0] frame_byte(
        input logic        we,
        input logic [15:0] addr,
        input logic [7:0]  wdat,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = we ? CMD_WRITE : CMD_READ;
            2'd1:    b = addr[15:8];
            2'd2:    b = addr[7:0];
            2'd3:    b = wdat;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Reset synchroniser and internal reset
    logic rst_meta_r;
    logic rst_sync_r;
    logic rst_n_s;

    // State and captured request
    logic [2:0]       state_r,    state_nxt_s;
    logic [1:0]       idx_r,      idx_nxt_s;
    logic [CNT_W-1:0] cnt_r,      cnt_nxt_s;
    logic             we_r,       we_nxt_s;
    logic [15:0]      addr_r,     addr_nxt_s;
    logic [7:0]       wdat_r,     wdat_nxt_s;

    // Registered outputs
    logic             busy_r,     busy_nxt_s;
    logic             done_r,     done_nxt_s;
    logic [7:0]       rdat_r,     rdat_nxt_s;
    logic             err_r,      err_nxt_s;
    logic             timeout_r,  timeout_nxt_s;
    logic             pulse_r,    pulse_nxt_s;
    logic [7:0]       udat_r,     udat_nxt_s;

    logic [1:0]       last_idx_s;

    assign rst_n_s    = rst_sync_r;
    assign last_idx_s = we_r ? 2'd3 : 2'd2;

    // Assert reset asynchronously, release it two clock edges later.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Next-state and next-output computation for the protocol FSM.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        cnt_nxt_s     = cnt_r;
        we_nxt_s      = we_r;
        addr_nxt_s    = addr_r;
        wdat_nxt_s    = wdat_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        rdat_nxt_s    = rdat_r;
        err_nxt_s     = err_r;
        timeout_nxt_s = timeout_r;
        pulse_nxt_s   = 1'b0;
        udat_nxt_s    = udat_r;

        case (state_r)
            ST_IDLE: begin
                if (i_req) begin
                    we_nxt_s      = i_we;
                    addr_nxt_s    = i_addr;
                    wdat_nxt_s    = i_wdat;
                    idx_nxt_s     = 2'd0;
                    err_nxt_s     = 1'b0;
                    timeout_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b1;
                    state_nxt_s   = ST_SEND;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The byte is latched with the strobe and held until the next one.
                if (i_uart_send_ready) begin
                    pulse_nxt_s = 1'b1;
                    udat_nxt_s  = frame_byte(we_r, addr_r, wdat_r, idx_r);
                    state_nxt_s = ST_WAIT_TXLOW;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT_TXLOW: begin
                if (!i_uart_send_ready) begin
                    state_nxt_s = ST_WAIT_TXHIGH;
                end else begin
                    state_nxt_s = ST_WAIT_TXLOW;
                end
            end
            ST_WAIT_TXHIGH: begin
                if (i_uart_send_ready) begin
                    if (idx_r == last_idx_s) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_WAIT_RX;
                    end else begin
                        idx_nxt_s   = idx_r + 2'd1;
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_TXHIGH;
                end
            end
            ST_WAIT_RX: begin
                // A reply arriving on the expiry cycle takes priority.
                if (i_uart_received_pulse) begin
                    done_nxt_s    = 1'b1;
                    timeout_nxt_s = 1'b0;
                    state_nxt_s   = ST_DONE;
                    if (we_r) begin
                        err_nxt_s  = (i_uart_dat != WRITE_ACK);
                    end else begin
                        rdat_nxt_s = i_uart_dat;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    done_nxt_s    = 1'b1;
                    timeout_nxt_s = 1'b1;
                    err_nxt_s     = 1'b0;
                    state_nxt_s   = ST_DONE;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_W'(1);
                    state_nxt_s   = ST_WAIT_RX;
                end
            end
            ST_DONE: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, captured request and output registers.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            cnt_r     <= '0;
            we_r      <= 1'b0;
            addr_r    <= 16'h0000;
            wdat_r    <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rdat_r    <= 8'h00;
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
            pulse_r   <= 1'b0;
            udat_r    <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            cnt_r     <= cnt_nxt_s;
            we_r      <= we_nxt_s;
            addr_r    <= addr_nxt_s;
            wdat_r    <= wdat_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            rdat_r    <= rdat_nxt_s;
            err_r     <= err_nxt_s;
            timeout_r <= timeout_nxt_s;
            pulse_r   <= pulse_nxt_s;
            udat_r    <= udat_nxt_s;
        end
    end

    assign o_busy            = busy_r;
    assign o_done            = done_r;
    assign o_rdat            = rdat_r;
    assign o_err             = err_r;
    assign o_timeout         = timeout_r;
    assign o_uart_send_pulse = pulse_r;
    assign o_uart_dat        = udat_r;

endmodule

// File: tb/tb_uart_host_protocol.sv
// Testbench for uart_host_protocol: behavioural UART transmitter model,
// scripted/random replies and a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_host_protocol;

    localparam int TO = 16;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        busy;
    logic        done;
    logic [7:0]  rdat;
    logic        err;
    logic        tmo;
    logic        send_pulse;
    logic [7:0]  uart_dat;
    logic        send_ready;
    logic        rx_pulse;
    logic [7:0]  rx_dat;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Transmitter model observations
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    int          tx_bad = 0;
    int          done_count = 0;
    int          done_double = 0;
    int          rx_entry_cyc = 0;
    int          low_len = 2;
    int          pre_stall = 0;

    logic [7:0]  model_rdat = 8'h00;

    uart_host_protocol #(.TIMEOUT(TO)) dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_req                 (req),
        .i_we                  (we),
        .i_addr                (addr),
        .i_wdat                (wdat),
        .o_busy                (busy),
        .o_done                (done),
        .o_rdat                (rdat),
        .o_err                 (err),
        .o_timeout             (tmo),
        .o_uart_send_pulse     (send_pulse),
        .o_uart_dat            (uart_dat),
        .i_uart_send_ready     (send_ready),
        .i_uart_received_pulse (rx_pulse),
        .i_uart_dat            (rx_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected frame contents for a request.
    function automatic byte_q_t frame_bytes(input logic f_we, input logic [15:0] f_addr,
                                            input logic [7:0] f_wdat);
        byte_q_t q;
        q = {};
        q.push_back(f_we ? 8'h57 : 8'h52);
        q.push_back(f_addr[15:8]);
        q.push_back(f_addr[7:0]);
        if (f_we) q.push_back(f_wdat);
        return q;
    endfunction

    // Transmitter model: logs each strobe, drops ready for low_len cycles after
    // it, optionally stalls before the first byte, and counts done pulses.
    initial begin : tx_model
        int   stall_cnt;
        logic prev_busy;
        logic prev_done;
        stall_cnt  = 0;
        prev_busy  = 1'b0;
        prev_done  = 1'b0;
        send_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (prev_done) done_double++;
            end
            prev_done = (done === 1'b1);
            if (send_pulse === 1'b1) begin
                tx_log.push_back(uart_dat);
                tx_cyc.push_back(cyc);
                if (send_ready !== 1'b1) tx_bad++;
                stall_cnt = low_len;
            end else if (busy === 1'b1 && !prev_busy && pre_stall > 0) begin
                stall_cnt = pre_stall;
            end
            prev_busy = (busy === 1'b1);
            if (stall_cnt > 0) begin
                send_ready = 1'b0;
                stall_cnt--;
            end else begin
                if (send_ready === 1'b0) rx_entry_cyc = cyc + 1;
                send_ready = 1'b1;
            end
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        rx_pulse = 1'b1;
        rx_dat   = b;
        @(negedge clk);
        rx_pulse = 1'b0;
        rx_dat   = 8'($urandom);
    endtask

    // One transaction. mode 0: no reply, 1: reply after frame, 2: reply on expiry cycle.
    task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [7:0] t_wdat,
                           input int mode, input logic [7:0] reply, input int t_low);
        byte_q_t    exp_q;
        int         base;
        int         acc;
        int         guard;
        logic [7:0] e_rdat;
        logic       e_err;
        logic       e_to;
        low_len = t_low;
        exp_q   = frame_bytes(t_we, t_addr, t_wdat);
        base    = tx_log.size();
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdat = t_wdat;
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdat = 8'($urandom);
        acc = cyc;
        n_checks++;
        if ({busy, err, tmo} !== 3'b100) begin
            n_fail++;
            $display("FAIL accept: busy/err/tmo=%b expected 100", {busy, err, tmo});
        end
        guard = 0;
        while (tx_log.size() < base + exp_q.size() && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (tx_log.size() != base + exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_len: got %0d bytes expected %0d", tx_log.size() - base, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tx_log[base + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL frame_byte[%0d]: got %h expected %h", i, tx_log[base + i], exp_q[i]);
                end
            end
            if (pre_stall == 0) begin
                n_checks++;
                if (tx_cyc[base] - acc != 1) begin
                    n_fail++;
                    $display("FAIL first_pulse_latency: got %0d expected 1", tx_cyc[base] - acc);
                end
            end
        end
        repeat (t_low + 2) @(negedge clk);
        e_rdat = model_rdat; e_err = 1'b0; e_to = 1'b0;
        if (mode == 0) begin
            e_to = 1'b1;
        end else begin
            if (mode == 2) begin
                guard = 0;
                while (cyc < rx_entry_cyc + TO - 1 && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
            end
            drive_rx(reply);
            if (t_we) e_err = (reply != 8'h4B);
            else      e_rdat = reply;
        end
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_wait: done=%b expected 1 within 100 cycles", done);
        end else begin
            n_checks++;
            if ({busy, err, tmo, rdat} !== {1'b1, e_err, e_to, e_rdat}) begin
                n_fail++;
                $display("FAIL result: busy/err/tmo/rdat=%b/%b/%b/%h expected 1/%b/%b/%h",
                         busy, err, tmo, rdat, e_err, e_to, e_rdat);
            end
            if (mode == 0) begin
                n_checks++;
                if (cyc != rx_entry_cyc + TO) begin
                    n_fail++;
                    $display("FAIL timeout_cycle: got %0d cycles expected %0d", cyc - rx_entry_cyc, TO);
                end
            end
            @(negedge clk);
            n_checks++;
            if ({done, busy, err, tmo} !== {2'b00, e_err, e_to}) begin
                n_fail++;
                $display("FAIL after_done: done/busy/err/tmo=%b expected %b",
                         {done, busy, err, tmo}, {2'b00, e_err, e_to});
            end
            n_checks++;
            if (tx_log.size() != base + exp_q.size()) begin
                n_fail++;
                $display("FAIL extra_pulses: got %0d bytes expected %0d", tx_log.size() - base, exp_q.size());
            end
        end
        model_rdat = e_rdat;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0000; wdat = 8'h00;
        rx_pulse = 1'b0; rx_dat = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, send_pulse, err, tmo, uart_dat, rdat} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h expected 0", {busy, done, send_pulse, err, tmo, uart_dat, rdat});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy, done, send_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_release: busy/done/pulse=%b expected 000", {busy, done, send_pulse});
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 16'h12A5, 8'h3C, 1, 8'h4B, 2);
    endtask

    task automatic test_read();
        run_txn(1'b0, 16'h0004, 8'h00, 1, 8'h99, 2);
    endtask

    task automatic test_bad_write();
        run_txn(1'b1, 16'($urandom), 8'($urandom), 1, 8'h00, 3);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        drive_rx(8'hE7);
        @(negedge clk);
        n_checks++;
        if ({busy, done, rdat} !== {2'b00, model_rdat}) begin
            n_fail++;
            $display("FAIL stray_rx: busy/done/rdat=%b/%b/%h expected 0/0/%h", busy, done, rdat, model_rdat);
        end
        run_txn(1'b0, 16'($urandom), 8'h00, 0, 8'h00, 2);
    endtask

    task automatic test_reply_at_expiry();
        run_txn(1'b0, 16'($urandom), 8'h00, 2, 8'h5A, 1);
        run_txn(1'b1, 16'($urandom), 8'($urandom), 2, 8'h11, 4);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int d0;
        int n_p;
        int guard;
        low_len = 3;
        base = tx_log.size();
        d0 = done_count;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'($urandom); wdat = 8'($urandom);
        @(negedge clk);
        req = 1'b0;
        guard = 0;
        while (tx_log.size() < base + 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, send_pulse, err, tmo, uart_dat, rdat} !== 21'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: outputs=%h expected 0", {busy, done, send_pulse, err, tmo, uart_dat, rdat});
        end
        n_p = tx_log.size();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (tx_log.size() != n_p || done_count != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: pulses=%0d done=%0d busy=%b expected %0d/%0d/0",
                     tx_log.size(), done_count, busy, n_p, d0);
        end
        model_rdat = 8'h00;
        run_txn(1'b0, 16'($urandom), 8'h00, 1, 8'($urandom), 2);
    endtask

    task automatic test_back_to_back();
        int         base;
        int         d0;
        int         guard;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  r0;
        logic [7:0]  r1;
        byte_q_t     exp_q;
        a0 = 16'($urandom); a1 = 16'($urandom); r0 = 8'($urandom); r1 = 8'($urandom);
        pre_stall = 5; low_len = 5;
        base = tx_log.size();
        d0 = done_count;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a0;
        for (int f = 0; f < 2; f++) begin
            guard = 0;
            while (tx_log.size() < base + 3 * (f + 1) && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            if (f == 0) addr = a1;
            repeat (7) @(negedge clk);
            drive_rx(f == 0 ? r0 : r1);
            n_checks++;
            if ({done, rdat} !== {1'b1, (f == 0 ? r0 : r1)}) begin
                n_fail++;
                $display("FAIL b2b_done[%0d]: done/rdat=%b/%h expected 1/%h", f, done, rdat, (f == 0 ? r0 : r1));
            end
            @(negedge clk);
            if (f == 0) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_gap: busy=%b expected 0", busy);
                end
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_reaccept: busy=%b expected 1", busy);
                end
                req = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        exp_q = frame_bytes(1'b0, a0, 8'h00);
        exp_q = {exp_q, frame_bytes(1'b0, a1, 8'h00)};
        n_checks++;
        if (tx_log.size() != base + 6 || done_count != d0 + 2) begin
            n_fail++;
            $display("FAIL b2b_counts: bytes=%0d done=%0d expected 6/2", tx_log.size() - base, done_count - d0);
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tx_log[base + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got %h expected %h", i, tx_log[base + i], exp_q[i]);
                end
            end
        end
        model_rdat = r1;
        pre_stall = 0;
        low_len = 2;
    endtask

    task automatic test_random();
        logic       w;
        logic [7:0] rep;
        int         m;
        for (int k = 0; k < 8; k++) begin
            m   = $urandom_range(0, 2);
            w   = 1'($urandom_range(0, 1));
            rep = ($urandom_range(0, 1) == 1) ? 8'h4B : 8'($urandom);
            run_txn(w, 16'($urandom), 8'($urandom), m, rep, $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_write();
        test_timeout();
        test_reply_at_expiry();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        n_checks++;
        if (tx_bad != 0 || done_double != 0) begin
            n_fail++;
            $display("FAIL protocol: pulses_without_ready=%0d long_done=%0d expected 0/0", tx_bad, done_double);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host_protocol.md
UART_HOST_PROTOCOL -- requirements
Module: uart_host_protocol

Interface
REQ-001 Parameter TIMEOUT, default 250000: response wait limit in i_clk cycles, counted from entry to WAIT_RX.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  transaction request; sampled only in IDLE.
REQ-005 i_we  input  1  1 = write, 0 = read; captured with i_req.
REQ-006 i_addr  input  16  target address; captured with i_req.
REQ-007 i_wdat  input  8  write data; captured with i_req.
REQ-008 o_busy  output  1  high from the cycle after acceptance until the o_done cycle, inclusive.
REQ-009 o_done  output  1  one-cycle completion pulse.
REQ-010 o_rdat  output  8  last successfully read byte.
REQ-011 o_err  output  1  valid with o_done: bad write reply.
REQ-012 o_timeout  output  1  valid with o_done: no reply within TIMEOUT.
REQ-013 o_uart_send_pulse  output  1  one-cycle start strobe to the byte transmitter.
REQ-014 o_uart_dat  output  8  byte to transmit; stable from pulse until the next pulse.
REQ-015 i_uart_send_ready  input  1  transmitter idle.
REQ-016 i_uart_received_pulse  input  1  one-cycle strobe: received byte valid.
REQ-017 i_uart_dat  input  8  received byte.

Function
REQ-018 Frames: write = 0x57, A[15:8], A[7:0], D, then the host expects reply 0x4B; read = 0x52, A[15:8], A[7:0], then reply = data byte.
REQ-019 States: IDLE, SEND, WAIT_TXLOW, WAIT_TXHIGH, WAIT_RX, DONE.
REQ-020 IDLE: i_req=1 captures i_we/i_addr/i_wdat, clears byte index to 0, and goes to SEND; o_busy rises the next cycle.
REQ-021 SEND: if i_uart_send_ready=1, assert o_uart_send_pulse for one cycle with o_uart_dat = frame byte[index], then go to WAIT_TXLOW; otherwise hold.
REQ-022 WAIT_TXLOW: wait for i_uart_send_ready=0, then go to WAIT_TXHIGH.
REQ-023 WAIT_TXHIGH: on i_uart_send_ready=1 either increment the index and return to SEND, or, if the last frame byte (index 3 write / 2 read) is done, clear the timeout counter and go to WAIT_RX.
REQ-024 WAIT_RX: on i_uart_received_pulse, go to DONE.
  - Read: o_rdat <= i_uart_dat.
  - Write: o_err <= (i_uart_dat != 0x4B).
REQ-025 WAIT_RX: the counter increments each cycle without a received pulse; on reaching TIMEOUT-1, go to DONE with o_timeout=1, o_rdat unchanged, o_err=0.
REQ-026 Simultaneous pulse and counter expiry: the received byte wins; o_timeout=0.
REQ-027 DONE: o_done=1 for exactly one cycle, o_busy=1, then IDLE; o_err/o_timeout hold until the next acceptance, which clears both.
REQ-028 i_req outside IDLE and in DONE is ignored; back-to-back: i_req held high is accepted the cycle after DONE.
REQ-029 i_uart_received_pulse outside WAIT_RX is discarded with no state change.
REQ-030 Minimum frame latency with an ideal transmitter: first send pulse 1 cycle after acceptance.
REQ-031 Timeout counter width is clog2(TIMEOUT) bits with no wrap; it is compared for equality against TIMEOUT-1.

Reset
REQ-032 i_reset low immediately forces IDLE and clears index, counter, o_busy, o_done, o_err, o_timeout, o_uart_send_pulse, o_uart_dat=0x00 and o_rdat=0x00.
REQ-033 Reset asserted mid-frame aborts the frame; no further pulses are emitted; no o_done is generated.
REQ-034 After release, the first i_req is accepted normally; release is synchronized by the implementation to avoid metastable state exit.

Verification
REQ-035 Write A=0x12A5, D=0x3C; model replies 0x4B -> pulses carry 0x57,0x12,0xA5,0x3C in order, then o_done with o_err=0 and o_timeout=0.
REQ-036 Read A=0x0004; model replies 0x99 -> pulses carry 0x52,0x00,0x04, then o_done with o_rdat=0x99.
REQ-037 Write with reply 0x00 -> o_done with o_err=1; o_rdat unchanged.
REQ-038 Read, no reply, TIMEOUT=16 -> o_done with o_timeout=1 exactly 16 cycles after WAIT_RX entry; a stray received pulse injected in IDLE beforehand has no effect.
REQ-039 i_reset low during byte 2 of a write -> all outputs at reset values, no further pulses; then a read completes correctly.
REQ-040 i_req held high across two reads with i_uart_send_ready stalled 5 cycles before each byte -> exactly two frames, each pulse only while ready=1, two o_done pulses.
